// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Memory-side responder for a cache: accepts one request at a time and
//   either returns a 4-word line fill or acknowledges a single-word write.
//   The backing store powers up holding mem[i] = i and keeps its contents
//   across rst_n.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we               0 = line fill, 1 = single-word write
//   req_addr             byte address (word index = addr[11:2])
//   req_wdata            write data
//   rsp_valid/rsp_ready  response beat handshake
//   rsp_data, rsp_last   beat payload and final-beat flag
//   busy                 high whenever not idle
//   fill_count           completed line fills (wraps)
//   write_count          completed writes (wraps)
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// WAIT  | request captured, counting down the access latency
// BURST | presenting fill beats 0..3
// WACK  | presenting the single write-acknowledge beat

module cache_mem_responder #(
  parameter int LATENCY        = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic [15:0] fill_count,
  output logic [15:0] write_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] LAST_BEAT = 2'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

  state_t        state;
  logic [3:0]    lat_cnt;
  logic [1:0]    beat;
  logic [AW-3:0] line_q;
  logic          we_q;
  logic [31:0]   wdata_q;

  logic [31:0]   rd_word [MEM_WORDS];
  logic          accept;
  logic          wr_en;
  logic          xfer;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [1:0]    beat_nxt;
  logic          unused_addr;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && rst_n;
  assign wr_idx    = req_addr[AW+1:2];
  assign xfer      = rsp_valid && rsp_ready;
  assign beat_nxt  = beat + 2'd1;

  // Entering BURST loads beat 0; each transfer inside BURST preloads the next beat.
  assign rd_idx = {line_q, (state == BURST) ? beat_nxt : 2'b00};

  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Per-word storage with a power-up value and no reset, so contents survive rst_n.
  for (genvar i = 0; i < MEM_WORDS; i++) begin : g_mem
    logic [31:0] word = 32'(i);
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == AW'(i))) word <= req_wdata;
    end
    assign rd_word[i] = word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat        <= '0;
      line_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      rsp_data    <= '0;
      fill_count  <= '0;
      write_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT;
            lat_cnt <= 4'(LATENCY - 1);
            line_q  <= req_addr[AW+1:4];
            we_q    <= req_we;
            wdata_q <= req_wdata;
            beat    <= '0;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            if (we_q) begin
              state    <= WACK;
              rsp_data <= wdata_q;
              rsp_last <= 1'b1;
            end else begin
              state    <= BURST;
              rsp_data <= rd_word[rd_idx];
              rsp_last <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        BURST: begin
          if (xfer) begin
            if (beat == LAST_BEAT) begin
              state      <= IDLE;
              rsp_valid  <= 1'b0;
              rsp_last   <= 1'b0;
              beat       <= '0;
              fill_count <= fill_count + 16'd1;
            end else begin
              beat     <= beat_nxt;
              rsp_data <= rd_word[rd_idx];
              rsp_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        WACK: begin
          if (xfer) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_last    <= 1'b0;
            write_count <= write_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Parameters
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the cycles from request accept to the first response beat (legal 1..15).
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, meaning the beats per line fill (fixed at 4).
REQ-003 The block SHALL have parameter MEM_WORDS, default 1024, meaning the backing store depth in 32-bit words.

Interface
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 req_valid  input  1  cache presents a request.
REQ-007 req_ready  output  1  responder accepts a request; high only in IDLE.
REQ-008 req_we  input  1  0 = line fill read, 1 = single-word write.
REQ-009 req_addr  input  32  byte address; word index = req_addr[11:2], line base = {req_addr[11:4],2'b00}.
REQ-010 req_wdata  input  32  write data, used when req_we=1.
REQ-011 rsp_valid  output  1  response beat valid.
REQ-012 rsp_ready  input  1  cache accepts the beat; a beat transfers when rsp_valid&&rsp_ready.
REQ-013 rsp_data  output  32  fill word, or echoed write data for a write ack.
REQ-014 rsp_last  output  1  final beat of the response.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 fill_count  output  16  completed line fills, wrapping at 0xFFFF->0.
REQ-017 write_count  output  16  completed writes, wrapping.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, BURST and WACK.
- IDLE -> WAIT on accept.
- WAIT -> BURST (read) or WACK (write) when the latency counter expires.
- BURST -> IDLE on the last-beat transfer.
- WACK -> IDLE on transfer.
REQ-019 Accept SHALL occur on the edge where req_valid&&req_ready; req_addr, req_we and req_wdata SHALL be registered at that edge, and later changes to the inputs SHALL be ignored.
REQ-020 On accept, the latency counter SHALL load LATENCY-1 and decrement each cycle in WAIT; leaving WAIT happens when the counter is 0, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 A fill SHALL return words line_base+0..+3 in ascending order regardless of req_addr[3:2], with no critical-word-first.
REQ-022 The beat counter SHALL advance only on transfer; rsp_data and rsp_last SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 rsp_last SHALL be 1 on beat 3 of a fill and on the single WACK beat, and 0 otherwise.
REQ-024 A write SHALL update memory at the word index on the accept edge; the WACK beat carries rsp_data = written data.
REQ-025 A fill SHALL observe all earlier completed writes, with no stale data.
REQ-026 Memory contents SHALL be initialised at time zero to mem[i] = i (32-bit), and SHALL NOT be cleared by rst_n.
REQ-027 fill_count SHALL increment on the last fill beat transfer, and write_count SHALL increment on the WACK transfer.
REQ-028 req_ready SHALL be 0 during the cycle of the final transfer, so a new accept is possible no earlier than the following cycle.
REQ-029 Address bits [31:12] and [1:0] SHALL be ignored.

Reset
REQ-030 While rst_n=0, the block SHALL force state=IDLE, req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, both counters=0, and the latency and beat counters=0.
REQ-031 Reset asserted mid-WAIT or mid-BURST SHALL abort the operation immediately with no further beats, and a write already accepted SHALL remain committed in memory.
REQ-032 The first accept after release SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 Fill at req_addr=0x44 with rsp_ready=1 -> rsp_valid rises 4 cycles after accept; beats 0x10,0x11,0x12,0x13 on consecutive cycles; rsp_last on 0x13; fill_count=1.
REQ-034 Same fill with rsp_ready toggling 1,0,0,1,... -> beats delivered in order with no duplication or loss, and data held stable during stalls.
REQ-035 Write 0xDEADBEEF to 0x48, then fill 0x40 -> WACK beat 0xDEADBEEF with rsp_last=1; the fill returns 0x10,0x11,0xDEADBEEF,0x13; write_count=1.
REQ-036 rst_n pulled low after beat 1 of a fill -> rsp_valid=0 asynchronously; after release, busy=0 and fill_count=0, and a new fill at 0x44 returns 0x10..0x13.
REQ-037 req_valid held high continuously for two fills -> req_ready=0 from accept through the final transfer, and the second accept occurs the cycle after the first rsp_last transfer.
REQ-038 LATENCY=1 build -> rsp_valid is high on the cycle immediately after the accept edge.
